// File: rtl/alu_iterative_if.sv
// Handshake and operand/result bundle between the control path and the iterative ALU.
interface alu_iterative_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output valid_in, alucontrol, src_a, src_b,
        input  ready_out, valid_out, result, zero, busy
    );

    modport slave (
        input  valid_in, alucontrol, src_a, src_b,
        output ready_out, valid_out, result, zero, busy
    );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a fixed-latency shift-add multiply.
// Optional feature macro: ALU_MUL_EN (when undefined, opcode 101 returns 0 in one cycle).
module alu_iterative #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_iterative_if.slave bus
);

    localparam logic [2:0] OP_MUL = 3'b101;

    logic [WIDTH-1:0] alu_res_c;
    logic             accept_c;
    logic             busy_c;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             valid_out_q;
    logic             slt_c;

    assign slt_c    = $signed(bus.src_a) < $signed(bus.src_b);
    assign accept_c = bus.valid_in && !busy_c;

    // Single-cycle result; the multiply opcode has no single-cycle value.
    always_comb begin
        alu_res_c = '0;
        case (bus.alucontrol)
            3'b000:  alu_res_c = bus.src_a & bus.src_b;
            3'b001:  alu_res_c = bus.src_a | bus.src_b;
            3'b010:  alu_res_c = bus.src_a + bus.src_b;
            3'b011:  alu_res_c = bus.src_a ^ bus.src_b;
            3'b100:  alu_res_c = bus.src_a - bus.src_b;
            3'b110:  alu_res_c = {{(WIDTH-1){1'b0}}, slt_c};
            3'b111:  alu_res_c = ~(bus.src_a | bus.src_b);
            default: alu_res_c = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] count_q;

    assign acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign busy_c = (state_q == S_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        if (bus.alucontrol == OP_MUL) begin
                            mcand_q  <= bus.src_a;
                            mplier_q <= bus.src_b;
                            acc_q    <= '0;
                            count_q  <= '0;
                            state_q  <= S_MUL;
                        end else begin
                            result_q    <= alu_res_c;
                            zero_q      <= (alu_res_c == '0);
                            valid_out_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                    // Last step folds into the result on the same edge.
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        result_q    <= acc_d;
                        zero_q      <= (acc_d == '0);
                        valid_out_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign busy_c = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= accept_c;
            if (accept_c) begin
                result_q <= alu_res_c;
                zero_q   <= (alu_res_c == '0);
            end
        end
    end
`endif

    assign bus.busy      = busy_c;
    assign bus.ready_out = !busy_c;
    assign bus.valid_out = valid_out_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Randomized bench for alu_iterative with a cycle-level behavioural model and directed spot checks.
module tb_alu_iterative;

    localparam int unsigned W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = MUL_EN ? 32 : 0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    alu_iterative_if #(.WIDTH(W)) bus ();

    alu_iterative #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return a - b;
            3'd5: return MUL_EN ? a * b : 32'd0;
            3'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return ~(a | b);
        endcase
    endfunction

    // Behavioural model: expected output values for the cycle following each edge.
    logic [31:0] m_result = '0;
    logic        m_zero   = 1'b1;
    logic        m_vout   = 1'b0;
    logic        m_busy   = 1'b0;
    int          m_left   = 0;
    logic [31:0] m_prod   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result = '0; m_zero = 1'b1; m_vout = 1'b0; m_busy = 1'b0; m_left = 0;
        end else begin
            m_vout = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_result = m_prod; m_zero = (m_prod == 0); m_vout = 1'b1;
                end
            end else if (bus.valid_in) begin
                if (bus.alucontrol == 3'd5 && MUL_EN) begin
                    m_busy = 1'b1; m_left = 32; m_prod = bus.src_a * bus.src_b;
                end else begin
                    m_result = ref_op(bus.alucontrol, bus.src_a, bus.src_b);
                    m_zero   = (m_result == 0);
                    m_vout   = 1'b1;
                end
            end
        end
    end

    // Single compare process, sampled mid-cycle.
    always @(negedge clk) begin
        chk("valid_out", 32'(bus.valid_out), 32'(m_vout));
        chk("busy",      32'(bus.busy),      32'(m_busy));
        chk("ready_out", 32'(bus.ready_out), 32'(!m_busy));
        chk("result",    bus.result,         m_result);
        chk("zero",      32'(bus.zero),      32'(m_zero));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; reports edges spent stalled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int waited);
        logic rdy;
        bit   done;
        done = 1'b0;
        waited = 0;
        bus.valid_in = 1'b1; bus.alucontrol = op; bus.src_a = a; bus.src_b = b;
        for (int t = 0; t < 200; t++) begin
            rdy = bus.ready_out;
            step();
            if (rdy) begin
                done = 1'b1;
                break;
            end
            waited++;
        end
        bus.valid_in = 1'b0;
        chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_vout(output int lat);
        bit ok;
        ok = 1'b0;
        lat = 0;
        for (int t = 0; t < 200; t++) begin
            if (bus.valid_out) begin
                ok = 1'b1;
                break;
            end
            step();
            lat++;
        end
        chk("vout_timeout", 32'(ok), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w;
        int lat;
        int pulses;
        bus.valid_in = 1'b0; bus.alucontrol = '0; bus.src_a = '0; bus.src_b = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_ready", 32'(bus.ready_out), 32'd1);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Add then back-to-back subtract.
        issue(3'b010, 32'd5, 32'd7, w);
        wait_vout(lat);
        chk("add_lat", 32'(lat), 32'd0);
        chk("add_result", bus.result, 32'd12);
        chk("add_zero", 32'(bus.zero), 32'd0);
        chk("model_add", m_result, 32'd12);
        issue(3'b100, 32'd3, 32'd5, w);
        chk("sub_vout", 32'(bus.valid_out), 32'd1);
        chk("sub_result", bus.result, 32'hFFFF_FFFE);

        // slt and zero flag.
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, w);
        chk("slt_result", bus.result, 32'd1);
        issue(3'b100, 32'd9, 32'd9, w);
        chk("sub0_result", bus.result, 32'd0);
        chk("sub0_zero", 32'(bus.zero), 32'd1);
        step();

        // Multiply latency and results.
        issue(3'b101, 32'd7, 32'hFFFF_FFFD, w);
        wait_vout(lat);
        chk("mul_lat", 32'(lat), 32'(MUL_LAT));
        chk("mul_result", bus.result, MUL_EN ? 32'hFFFF_FFEB : 32'd0);
        chk("model_mul", m_result, MUL_EN ? 32'hFFFF_FFEB : 32'd0);
        step();
        issue(3'b101, 32'h0001_0000, 32'h0001_0000, w);
        wait_vout(lat);
        chk("mul0_result", bus.result, 32'd0);
        chk("mul0_zero", 32'(bus.zero), 32'd1);
        step();

        // Request held across a multiply is accepted only once ready returns.
        issue(3'b101, 32'd7, 32'hFFFF_FFFD, w);
        issue(3'b010, 32'd1, 32'd1, w);
        chk("stall_wait", 32'(w), 32'(MUL_LAT));
        chk("stall_vout", 32'(bus.valid_out), 32'd1);
        chk("stall_result", bus.result, 32'd2);
        step();
        chk("stall_single", 32'(bus.valid_out), 32'd0);

        // Opcode 101 with multiply disabled is a single-cycle zero.
        issue(3'b101, 32'd3, 32'd4, w);
        chk("op5_wait", 32'(w), 32'd0);
        wait_vout(lat);
        chk("op5_result", bus.result, MUL_EN ? 32'd12 : 32'd0);
        chk("op5_zero", 32'(bus.zero), MUL_EN ? 32'd0 : 32'd1);
        step();

        // Reset in the middle of a multiply.
        issue(3'b101, 32'h1234, 32'h5678, w);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_result", bus.result, 32'd0);
        chk("rstmid_zero", 32'(bus.zero), 32'd1);
        chk("rstmid_vout", 32'(bus.valid_out), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.valid_out) pulses++;
        end
        chk("rstmid_no_pulse", 32'(pulses), 32'd0);

        // Randomized traffic with random gaps.
        for (int i = 0; i < 400; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), w);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Execute-stage ALU that consumes the 3-bit `alucontrol` code from the ALU decoder plus two operands, and produces a registered result and zero flag. Add, subtract, set-less-than and logic ops complete in one cycle. Multiply (`alucontrol = 3'b101`) runs as a fixed-latency radix-2 shift-add sequence. A valid/ready handshake toward the control path stalls issue while a multiply is in flight.

## Interface
- `WIDTH`, 32, operand and result width in bits (≥ 2)
- `clk`  input  1  clock, all state updates on rising edge
- `rst_n`  input  1  reset, asynchronous assert, active-low
- `valid_in`  input  1  operation request
- `ready_out`  output  1  unit can accept; equals !busy
- `alucontrol`  input  3  operation code from ALU decoder
- `src_a`  input  WIDTH  operand A
- `src_b`  input  WIDTH  operand B
- `valid_out`  output  1  one-cycle pulse: `result`/`zero` updated
- `result`  output  WIDTH  registered result, held until next completion
- `zero`  output  1  registered, (result == 0)
- `busy`  output  1  multiply in progress

## Operation
- Accept = `valid_in && ready_out` at a rising edge; operands and code are sampled at that edge only.
- Opcodes, all results modulo 2^WIDTH:
  - 000: A & B
  - 001: A | B
  - 010: A + B
  - 011: A ^ B
  - 100: A − B
  - 101: A × B, low WIDTH bits; signed and unsigned give identical low bits
  - 110: slt, 1 if signed A < signed B, else 0
  - 111: ~(A | B)
- States: IDLE, MUL.
- IDLE, accept, non-multiply: `result`, `zero` and `valid_out = 1` are registered at the accept edge. The unit stays in IDLE.
- IDLE, accept, opcode 101: load multiplicand = A, multiplier = B, acc = 0, count = 0. Go to MUL with `busy = 1`.
- MUL, each edge:
  - if multiplier[0], acc += multiplicand
  - multiplicand <<= 1; multiplier >>= 1; count++
  - on the edge where count == WIDTH−1: write the final acc (including this step) to `result`, update `zero`, assert `valid_out`, clear `busy`, return to IDLE.
- No early termination; multiply latency is fixed.
- `valid_in` while `busy`: ignored, nothing latched. The requester must hold the request.
- Reset (any time, including mid-multiply): aborts the operation and returns to IDLE.
- Reset values:
  - `result` = 0, `zero` = 1
  - `valid_out` = 0, `busy` = 0, `ready_out` = 1
  - acc, multiplicand, multiplier, count = 0

## Timing
- Single-cycle op accepted at edge k: `valid_out` high in cycle k→k+1. Throughput is one op per cycle; back-to-back accepts give consecutive `valid_out` pulses.
- Multiply accepted at edge k:
  - `busy` = 1 and `ready_out` = 0 for cycles k→k+WIDTH
  - `valid_out` high in cycle k+WIDTH→k+WIDTH+1
  - `ready_out` = 1 in that same cycle, so a new op may be accepted at edge k+WIDTH+1
- `valid_out` is never high for two cycles from one request.
- `ready_out` is combinational from the `busy` register only; there is no path from `valid_in` to `ready_out`.

## Configuration
- `ALU_MUL_EN` defined: opcode 101 runs the iterative multiply described above. The multiplier datapath and the MUL state are present.
- `ALU_MUL_EN` undefined:
  - no multiplier datapath; MUL state removed
  - opcode 101 completes as a single-cycle op with `result = 0`, `zero = 1`
  - `busy` is constantly 0 and `ready_out` constantly 1

## Test plan
All scenarios use WIDTH = 32.
- Add: accept 010, A = 5, B = 7 → next cycle `valid_out` = 1, `result` = 12, `zero` = 0. Then 100, A = 3, B = 5 on the following edge → `result` = 0xFFFFFFFE.
- slt / zero: 110 with A = 0xFFFFFFFF, B = 1 → `result` = 1. Then 100 with A = B = 9 → `result` = 0, `zero` = 1.
- Multiply:
  - 101, A = 7, B = 0xFFFFFFFD → `ready_out` low for exactly 32 cycles, then `valid_out` pulse with `result` = 0xFFFFFFEB.
  - A = B = 0x00010000 → `result` = 0, `zero` = 1.
- Busy stall: hold `valid_in` with 010, A = 1, B = 1 during a multiply → not accepted until `ready_out` returns. Then a single `valid_out` with `result` = 2 occurs one cycle after the multiply's `valid_out`.
- Reset mid-multiply: assert `rst_n` = 0 at cycle 10 of a multiply → immediately `busy` = 0, `result` = 0, `zero` = 1, `valid_out` = 0. No completion pulse after release.
- `ALU_MUL_EN` undefined: 101, A = 3, B = 4 → next cycle `valid_out` = 1, `result` = 0, `zero` = 1, `ready_out` never low.
